cmp_share_arbiter: RTL and testbench
====================================

Name: cmp_share_arbiter

Overview:
- Shares one instance of the existing 32-bit signed/unsigned comparator between two requesters.
  - Port 0: branch resolution unit (BEQ/BNE/BLTZ/BGEZ/BGTZ/BLEZ).
  - Port 1: ALU set-less-than path (SLT/SLTU/SLTI/SLTIU).
- Arbitrates, registers operands, decodes the compare op and returns a tagged one-bit result.
- Two-stage pipeline, throughput one compare per cycle.

Parameters:
- TAG_W, 4, width of per-request tag returned with the result.
- NREQ, 2, number of requesters. Fixed at 2; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill all in-flight compares; blocks acceptance this cycle.
- req_valid  input  2  bit i = requester i has a request.
- req_ready  output  2  bit i = request i accepted this cycle (valid&ready).
- req_a  input  64  operand A; port i occupies bits [32*i +: 32].
- req_b  input  64  operand B; same packing as req_a.
- req_signed  input  2  bit i = signed compare for port i.
- req_op  input  6  3-bit op per port at [3*i +: 3].
- req_tag  input  2*TAG_W  tag per port at [TAG_W*i +: TAG_W].
- resp_valid  output  2  one-cycle pulse, result for port i.
- resp_result  output  1  compare outcome.
- resp_tag  output  TAG_W  tag of the completed request.
- busy  output  1  stage-1 register holds a valid request.

Behaviour:
- Op encoding (in package):
  - 0 EQ: equal.
  - 1 NE: !equal.
  - 2 LT: less.
  - 3 GE: !less.
  - 4 GT: bigger.
  - 5 LE: !bigger.
  - 6, 7: reserved; result 0, response still issued.
- Arbitration:
  - Combinational grant from req_valid.
  - Single request: it wins.
  - Both valid: the port not granted most recently wins (round-robin).
  - last_grant updates only on an actual accept.
  - req_ready[i] = grant[i] & ~flush; at most one bit set.
- Requester handshake:
  - Requester holds a, b, signed, op, tag stable while valid and not ready.
  - Requester may not drop valid before ready; the bench checks this as an assertion.
- Stage 1 (cycle T, accept): latch a, b, signed, op, tag and port into s1 registers; s1_valid <= 1.
  - No accept at T means s1_valid <= 0.
- Stage 2 (cycle T+1):
  - Comparator is driven from s1 registers; enable = s1 signed.
  - Op decode is applied, then result, tag and port are registered.
  - resp_valid[port] = 1 during cycle T+2; all other bits 0.
- Latency: accept edge to resp_valid is exactly 2 cycles. Back-to-back accepts give back-to-back responses with no bubble.
- No response backpressure: requesters must consume resp_valid when it pulses.
- Hold values:
  - resp_result and resp_tag hold their last value when resp_valid = 0.
  - After reset they are 0.
- Flush at cycle T:
  - req_ready = 0 at T.
  - s1_valid <= 0, so a request accepted at T-1 is dropped.
  - Any response already visible at T is unaffected.
  - The next possible response appears at T+3 or later.
- Reset (rst high at edge), mid-operation included:
  - req_ready is not generated: it is forced 0 while rst is high.
  - s1_valid = 0, resp_valid = 0, resp_result = 0, resp_tag = 0, busy = 0.
  - last_grant = 1, so port 0 wins the first tie.
- Signed compare uses two's complement; unsigned compare uses magnitude. Equal is independent of req_signed.

Optional Feature:
- Macro: CMP_PRIO_BRANCH_EN.
- Defined: fixed priority; port 0 (branch) always wins when both valid. last_grant is unused and no register is synthesized for it.
- Undefined: round-robin as above.

Decomposition:
- Package cmp_arb_pkg:
  - CMP_OP_EQ..CMP_OP_LE localparams and CMP_OP_W = 3.
  - PORT_BR = 0, PORT_ALU = 1.
  - Function cmp_decode(op, bigger, equal, less) returning the result bit.
- Sub-modules:
  - Instantiate the existing signed_compare_32bit unchanged (a, b, enable → bigger, equal, less).
  - One natural sub-module: cmp_rr_arb2, the two-way grant plus last_grant register, including the CMP_PRIO_BRANCH_EN variant.

Test Plan:
- Port 0 alone, a = 0xFFFFFFFF, b = 0x00000001, op LT, signed = 1, tag 3 → accepted at T; resp_valid = 2'b01 at T+2, result 1, tag 3. Same with signed = 0 → result 0.
- Both ports valid for 4 cycles after reset, port 0 GT 5 > 3, port 1 GE 0x80000000 vs 0 unsigned → grants alternate 0, 1, 0, 1; four consecutive responses, all result 1, tags in order. With CMP_PRIO_BRANCH_EN → port 0 granted every cycle, port 1 ready stays 0.
- Flush in the cycle after port 1 accepts (EQ 7, 7) → no resp at T+2; req_ready = 0 during flush; a new request accepted at T+2 responds at T+4.
- rst asserted with both pipeline stages valid → next cycle resp_valid = 0, busy = 0; first tie after reset goes to port 0.
- Sweep all six ops, both signedness settings, over the corner pairs {0, 1, 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF} → results match the reference model. Op 6 → response issued with result 0.

Source files
------------

// File: rtl/cmp_share_arbiter_pkg.sv
// Shared definitions for the comparator-sharing arbiter: compare op codes, port ids and op decode.
// Optional build macro CMP_PRIO_BRANCH_EN (see cmp_rr_arb2) selects fixed branch priority.
package cmp_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int CMP_OP_W = 3;

    localparam logic [CMP_OP_W-1:0] CMP_OP_EQ = 3'd0;
    localparam logic [CMP_OP_W-1:0] CMP_OP_NE = 3'd1;
    localparam logic [CMP_OP_W-1:0] CMP_OP_LT = 3'd2;
    localparam logic [CMP_OP_W-1:0] CMP_OP_GE = 3'd3;
    localparam logic [CMP_OP_W-1:0] CMP_OP_GT = 3'd4;
    localparam logic [CMP_OP_W-1:0] CMP_OP_LE = 3'd5;

    localparam int PORT_BR  = 0;
    localparam int PORT_ALU = 1;

    // Reserved op codes still produce a response, with a 0 result.
    function automatic logic cmp_decode(input logic [CMP_OP_W-1:0] op,
                                        input logic bigger,
                                        input logic equal,
                                        input logic less);
        case (op)
            CMP_OP_EQ: return equal;
            CMP_OP_NE: return ~equal;
            CMP_OP_LT: return less;
            CMP_OP_GE: return ~less;
            CMP_OP_GT: return bigger;
            CMP_OP_LE: return ~bigger;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle between the two requesters (master) and the shared comparator (slave).
// Optional build macro CMP_PRIO_BRANCH_EN does not change this interface.
interface cmp_share_arbiter_if
    import cmp_arb_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic                    flush;
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [2*DATA_W-1:0]     req_a;
    logic [2*DATA_W-1:0]     req_b;
    logic [1:0]              req_signed;
    logic [2*CMP_OP_W-1:0]   req_op;
    logic [2*TAG_W-1:0]      req_tag;
    logic [1:0]              resp_valid;
    logic                    resp_result;
    logic [TAG_W-1:0]        resp_tag;
    logic                    busy;

    modport master (
        output flush, req_valid, req_a, req_b, req_signed, req_op, req_tag,
        input  req_ready, resp_valid, resp_result, resp_tag, busy
    );

    modport slave (
        input  flush, req_valid, req_a, req_b, req_signed, req_op, req_tag,
        output req_ready, resp_valid, resp_result, resp_tag, busy
    );

endinterface

// File: rtl/cmp_share_arbiter_arb.sv
// Two-way grant for cmp_rr_arb2: round-robin on ties by default; with CMP_PRIO_BRANCH_EN defined,
// the branch port always wins and no last-grant state exists.
module cmp_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_flush,
    output logic [1:0] o_ready
);
    logic [1:0] w_grant;

`ifdef CMP_PRIO_BRANCH_EN
    always_comb begin
        w_grant = 2'b00;
        if (i_valid[0])      w_grant = 2'b01;
        else if (i_valid[1]) w_grant = 2'b10;
    end
`else
    logic r_last_grant;

    // On a tie the port that did not win most recently is served.
    always_comb begin
        w_grant = i_valid;
        if (i_valid == 2'b11) w_grant = r_last_grant ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst)            r_last_grant <= 1'b1;
        else if (|o_ready)  r_last_grant <= o_ready[1];
    end
`endif

    assign o_ready = w_grant & {2{~(i_flush | rst)}};

endmodule

// File: rtl/signed_compare_32bit.sv
// Existing 32-bit comparator: enable selects two's-complement ordering, otherwise magnitude.
// Optional build macro CMP_PRIO_BRANCH_EN does not affect this module.
module signed_compare_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        enable,
    output logic        bigger,
    output logic        equal,
    output logic        less
);
    always_comb begin
        equal = (a == b);
        if (enable) begin
            less   = ($signed(a) < $signed(b));
            bigger = ($signed(a) > $signed(b));
        end else begin
            less   = (a < b);
            bigger = (a > b);
        end
    end
endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one 32-bit comparator between the branch unit (port 0) and the SLT path (port 1),
// two-stage pipeline; CMP_PRIO_BRANCH_EN selects fixed branch priority in the arbiter.
module cmp_share_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int NREQ  = 2
) (
    input logic              clk,
    input logic              rst,
    cmp_share_arbiter_if.slave bus
);
    logic [NREQ-1:0]     w_accept;
    logic                w_sel;
    logic                w_bigger;
    logic                w_equal;
    logic                w_less;
    logic                w_res;

    logic                r_vld_p1;
    logic [DATA_W-1:0]   r_a_p1;
    logic [DATA_W-1:0]   r_b_p1;
    logic                r_sgn_p1;
    logic [CMP_OP_W-1:0] r_op_p1;
    logic [TAG_W-1:0]    r_tag_p1;
    logic                r_port_p1;

    logic                r_vld_p2;
    logic                r_res_p2;
    logic [TAG_W-1:0]    r_tag_p2;
    logic                r_port_p2;

    cmp_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.req_valid),
        .i_flush (bus.flush),
        .o_ready (w_accept)
    );

    assign bus.req_ready = w_accept;
    assign w_sel         = w_accept[PORT_ALU];

    // Stage 1: capture the accepted request
    always_ff @(posedge clk) begin
        if (rst || bus.flush) r_vld_p1 <= 1'b0;
        else                  r_vld_p1 <= |w_accept;
    end

    always_ff @(posedge clk) begin
        if (|w_accept) begin
            r_a_p1    <= w_sel ? bus.req_a[DATA_W +: DATA_W]       : bus.req_a[0 +: DATA_W];
            r_b_p1    <= w_sel ? bus.req_b[DATA_W +: DATA_W]       : bus.req_b[0 +: DATA_W];
            r_sgn_p1  <= w_sel ? bus.req_signed[PORT_ALU]          : bus.req_signed[PORT_BR];
            r_op_p1   <= w_sel ? bus.req_op[CMP_OP_W +: CMP_OP_W]  : bus.req_op[0 +: CMP_OP_W];
            r_tag_p1  <= w_sel ? bus.req_tag[TAG_W +: TAG_W]       : bus.req_tag[0 +: TAG_W];
            r_port_p1 <= w_sel;
        end
    end

    signed_compare_32bit u_cmp (
        .a      (r_a_p1),
        .b      (r_b_p1),
        .enable (r_sgn_p1),
        .bigger (w_bigger),
        .equal  (w_equal),
        .less   (w_less)
    );

    assign w_res = cmp_decode(r_op_p1, w_bigger, w_equal, w_less);

    // Stage 2: register decoded result; flush kills the stage-1 entry here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_res_p2  <= 1'b0;
            r_tag_p2  <= '0;
            r_port_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1 & ~bus.flush;
            if (r_vld_p1 && !bus.flush) begin
                r_res_p2  <= w_res;
                r_tag_p2  <= r_tag_p1;
                r_port_p2 <= r_port_p1;
            end
        end
    end

    assign bus.resp_valid[PORT_BR]  = r_vld_p2 & ~r_port_p2;
    assign bus.resp_valid[PORT_ALU] = r_vld_p2 &  r_port_p2;
    assign bus.resp_result          = r_res_p2;
    assign bus.resp_tag             = r_tag_p2;
    assign bus.busy                 = r_vld_p1;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Randomized and directed bench for cmp_share_arbiter against a transaction-level reference model.
// Build with +define+CMP_PRIO_BRANCH_EN to check the fixed-priority variant.
module tb_cmp_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fl  = 1'b0;
    always #5 clk = ~clk;

    cmp_share_arbiter_if #(.TAG_W(4)) bus();

    cmp_share_arbiter #(.TAG_W(4), .NREQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Pending request per requester, held until accepted
    logic [1:0]        pv = 2'b00;
    logic [1:0]        ps = 2'b00;
    logic [1:0][31:0]  pa = '0;
    logic [1:0][31:0]  pb = '0;
    logic [1:0][2:0]   pop = '0;
    logic [1:0][3:0]   ptag = '0;

    // Reference model state: what is in flight, what the outputs hold
    bit        m_s1v = 0, m_s2v = 0, m_last = 1;
    int        m_s1p = 0, m_s2p = 0;
    bit        m_s1r = 0, m_res = 0;
    bit [3:0]  m_s1t = 0, m_tag = 0;
    logic [1:0] obs_rdy;

    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    function automatic bit ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic [2:0] op);
        bit eq, lt, gt;
        eq = (a == b);
        lt = s ? (int'(a) < int'(b)) : (a < b);
        gt = s ? (int'(a) > int'(b)) : (a > b);
        case (op)
            3'd0: return eq;
            3'd1: return !eq;
            3'd2: return lt;
            3'd3: return !lt;
            3'd4: return gt;
            3'd5: return !gt;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] model_grant();
        if (pv != 2'b11) return pv;
`ifdef CMP_PRIO_BRANCH_EN
        return 2'b01;
`else
        return (m_last == 1) ? 2'b01 : 2'b10;
`endif
    endfunction

    function automatic logic [31:0] rnd_operand();
        if ($urandom_range(1, 0) == 0) return corner[$urandom_range(4, 0)];
        return $urandom;
    endfunction

    task automatic arm(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [2:0] op, input logic [3:0] tag);
        pv[p] = 1'b1; pa[p] = a; pb[p] = b; ps[p] = s; pop[p] = op; ptag[p] = tag;
    endtask

    // One clock: drive, check ready mid-cycle, advance model, check registered outputs
    task automatic step();
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;
        int         p;
        bus.req_valid = pv; bus.req_a = pa; bus.req_b = pb; bus.req_signed = ps;
        bus.req_op = pop; bus.req_tag = ptag; bus.flush = fl;
        @(negedge clk);
        exp_rdy = (rst || fl) ? 2'b00 : model_grant();
        obs_rdy = bus.req_ready;
        checks++;
        if (obs_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready t=%0t got %b exp %b", $time, obs_rdy, exp_rdy);
        end
        if (rst) begin
            m_s1v = 0; m_s2v = 0; m_res = 0; m_tag = 0; m_last = 1;
        end else begin
            m_s2v = m_s1v && !fl;
            if (m_s2v) begin m_s2p = m_s1p; m_res = m_s1r; m_tag = m_s1t; end
            m_s1v = (exp_rdy != 2'b00);
            if (m_s1v) begin
                p = exp_rdy[1] ? 1 : 0;
                m_s1p = p; m_s1t = ptag[p]; m_s1r = ref_cmp(pa[p], pb[p], ps[p], pop[p]);
`ifndef CMP_PRIO_BRANCH_EN
                m_last = p[0];
`endif
            end
        end
        @(posedge clk);
        #1;
        exp_rv = m_s2v ? (2'b01 << m_s2p) : 2'b00;
        checks++;
        if (bus.resp_valid !== exp_rv || bus.resp_result !== m_res ||
            bus.resp_tag !== m_tag || bus.busy !== m_s1v) begin
            errors++;
            $display("FAIL resp t=%0t got v=%b r=%b t=%h busy=%b exp v=%b r=%b t=%h busy=%b",
                     $time, bus.resp_valid, bus.resp_result, bus.resp_tag, bus.busy,
                     exp_rv, m_res, m_tag, m_s1v);
        end
        pv = pv & ~exp_rdy;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && pv != 2'b00; i++) step();
        if (pv != 2'b00) begin
            checks++; errors++;
            $display("FAIL drain pending got %b exp 00", pv);
        end
        step(); step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arm(0, 32'd1, 32'd2, 1'b0, 3'd2, 4'd1);
        arm(1, 32'd3, 32'd4, 1'b0, 3'd2, 4'd2);
        step();
        checks++;
        if (obs_rdy !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", obs_rdy); end
        pv = 2'b00;
        step();
        checks++;
        if (bus.resp_valid !== 2'b00 || bus.resp_result !== 1'b0 ||
            bus.resp_tag !== 4'h0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b r=%b t=%h b=%b exp 00 0 0 0",
                     bus.resp_valid, bus.resp_result, bus.resp_tag, bus.busy);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lt_sign();
        for (int s = 1; s >= 0; s--) begin
            arm(0, 32'hFFFF_FFFF, 32'h0000_0001, s[0], 3'd2, 4'd3);
            step(); step();
            checks++;
            if (bus.resp_valid !== 2'b01 || bus.resp_result !== s[0] || bus.resp_tag !== 4'd3) begin
                errors++;
                $display("FAIL lt_sign s=%0d got v=%b r=%b t=%h exp 01 %0d 3",
                         s, bus.resp_valid, bus.resp_result, bus.resp_tag, s);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_seq [4];
`ifdef CMP_PRIO_BRANCH_EN
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rst = 1'b1; pv = 2'b00; step(); rst = 1'b0;
        arm(0, 32'd5, 32'd3, 1'b1, 3'd4, 4'd0);
        arm(1, 32'h8000_0000, 32'd0, 1'b0, 3'd3, 4'd8);
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (obs_rdy !== exp_seq[c]) begin
                errors++;
                $display("FAIL rr_grant c=%0d got %b exp %b", c, obs_rdy, exp_seq[c]);
            end
            if (c < 3) begin
                if (!pv[0]) arm(0, 32'd5, 32'd3, 1'b1, 3'd4, 4'(c + 1));
                if (!pv[1]) arm(1, 32'h8000_0000, 32'd0, 1'b0, 3'd3, 4'(c + 9));
            end
            if (c >= 2) begin
                checks++;
                if (bus.resp_result !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_result c=%0d got %b exp 1", c, bus.resp_result);
                end
            end
        end
        drain();
    endtask

    task automatic test_flush();
        arm(1, 32'd7, 32'd7, 1'b0, 3'd0, 4'd5);
        step();
        checks++;
        if (obs_rdy !== 2'b10) begin errors++; $display("FAIL flush_acc got %b exp 10", obs_rdy); end
        fl = 1'b1;
        arm(0, 32'd10, 32'd20, 1'b1, 3'd2, 4'd6);
        step();
        fl = 1'b0;
        checks++;
        if (obs_rdy !== 2'b00 || bus.resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL flush_kill got rdy=%b v=%b exp 00 00", obs_rdy, bus.resp_valid);
        end
        step();
        checks++;
        if (obs_rdy !== 2'b01 || bus.resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL flush_next got rdy=%b v=%b exp 01 00", obs_rdy, bus.resp_valid);
        end
        step();
        checks++;
        if (bus.resp_valid !== 2'b01 || bus.resp_result !== 1'b1 || bus.resp_tag !== 4'd6) begin
            errors++;
            $display("FAIL flush_resp got v=%b r=%b t=%h exp 01 1 6",
                     bus.resp_valid, bus.resp_result, bus.resp_tag);
        end
        step();
    endtask

    task automatic test_reset_mid();
        arm(0, 32'd1, 32'd1, 1'b0, 3'd0, 4'd1);
        arm(1, 32'd2, 32'd1, 1'b0, 3'd4, 4'd2);
        step();
        if (!pv[0]) arm(0, 32'd1, 32'd1, 1'b0, 3'd0, 4'd3);
        if (!pv[1]) arm(1, 32'd2, 32'd1, 1'b0, 3'd4, 4'd4);
        step();
        rst = 1'b1; pv = 2'b00;
        step();
        rst = 1'b0;
        checks++;
        if (bus.resp_valid !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got v=%b busy=%b exp 00 0", bus.resp_valid, bus.busy);
        end
        arm(0, 32'd9, 32'd9, 1'b0, 3'd0, 4'd7);
        arm(1, 32'd9, 32'd8, 1'b0, 3'd5, 4'd8);
        step();
        checks++;
        if (obs_rdy !== 2'b01) begin errors++; $display("FAIL reset_tie got %b exp 01", obs_rdy); end
        drain();
    endtask

    task automatic test_sweep();
        int tag = 0;
        for (int op = 0; op < 8; op++)
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++) begin
                        arm($urandom_range(1, 0), corner[i], corner[j], s[0], op[2:0], 4'(tag));
                        tag++;
                        step();
                    end
        step(); step();
        arm(1, 32'd4, 32'd4, 1'b0, 3'd6, 4'hA);
        step(); step();
        checks++;
        if (bus.resp_valid !== 2'b10 || bus.resp_result !== 1'b0 || bus.resp_tag !== 4'hA) begin
            errors++;
            $display("FAIL op6 got v=%b r=%b t=%h exp 10 0 a",
                     bus.resp_valid, bus.resp_result, bus.resp_tag);
        end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++)
                if (!pv[p] && $urandom_range(3, 0) != 0)
                    arm(p, rnd_operand(), rnd_operand(), 1'($urandom_range(1, 0)),
                        3'($urandom_range(7, 0)), 4'($urandom_range(15, 0)));
            fl = ($urandom_range(9, 0) == 0);
            step();
        end
        fl = 1'b0;
        drain();
    endtask

    // Requesters must not withdraw a request before it is accepted
    logic [1:0] hold_q = 2'b00;
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (hold_q[i] && !rst)
                assert (bus.req_valid[i]) else $error("requester %0d dropped valid before ready", i);
        hold_q <= bus.req_valid & ~bus.req_ready & {2{~rst}};
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lt_sign();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
